adder_arbiter: RTL and testbench
================================

# adder_arbiter

Shares one registered adder (2-bit operands, 3-bit sum, clocked, active-high reset) between NREQ requesters. Each cycle it grants at most one pending request, drives the granted operands onto the adder inputs, tracks the requester ID through the adder latency, and returns the registered sum tagged with that ID. It also sequences the adder's reset after system reset.

## Interface
- NREQ, 4: number of requesters, 2..8.
- W, 2: operand width; sum width is W+1.
- LAT, 1: adder latency in cycles from operands to valid add_s, 1..4.
- IDW, 2: ID width, equal to clog2(NREQ).

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  grant enable; when low no new grants, in-flight work drains.
- req  in  NREQ  per-requester request, held until granted.
- op_a  in  NREQ*W  operand A, requester i at bits [i*W +: W].
- op_b  in  NREQ*W  operand B, same packing.
- gnt  out  NREQ  one-hot grant, combinational, at most one bit set.
- add_a  out  W  adder operand A (mux of granted requester, 0 when idle).
- add_b  out  W  adder operand B (same).
- add_rst  out  1  active-high adder reset.
- add_s  in  W+1  adder sum, valid LAT cycles after issue.
- rsp_vld  out  1  registered response valid, one-cycle pulse per grant.
- rsp_id  out  IDW  requester index of the response.
- rsp_s  out  W+1  sum of the response.
- busy  out  1  high while any issued operation has not yet been returned.

## Operation
- Sequencer states: RST (reset low), HOLD (add_rst high for 2 cycles after reset release), RUN.
- gnt is forced to 0 unless state is RUN and en=1.
- Issue: in RUN with en=1 and req≠0, exactly one gnt bit is set. Its operands appear on add_a/add_b in the same cycle. The requester drops or changes req after seeing gnt at the clock edge.
- Arbitration (see Configuration): round-robin. The pointer starts at 0 after reset. After granting index g, the pointer moves to (g+1) mod NREQ. The search starts at the pointer and wraps.
- Tag pipeline: valid and ID shift through LAT stages. At the stage-LAT output, register rsp_vld/rsp_id and register rsp_s ← add_s.
- Outstanding counter, 0..LAT+1: increments on issue, decrements on rsp_vld. Both in one cycle leaves it unchanged. busy = (count≠0).
- Back-to-back grants are allowed every cycle. Throughput is 1 op/cycle and responses arrive in issue order.
- Sum arithmetic: rsp_s = op_a + op_b, zero-extended to W+1. There is no overflow (3+3=6 for W=2).
- en falling mid-stream: no new grants, but all issued ops still return.
- reset asserted mid-operation: all in-flight tags are discarded, no rsp_vld for them, and the sequencer returns to RST.

## Timing
- Reset values: gnt=0, add_a=0, add_b=0, add_rst=1, rsp_vld=0, rsp_id=0, rsp_s=0, busy=0, pointer=0, count=0.
- add_rst stays 1 during reset and for the first 2 rising edges after reset deasserts. It drops to 0 on the 2nd edge. The first grant is possible in the cycle after that.
- Latency: issue in cycle N gives rsp_vld=1 in cycle N+LAT+1, which lasts one cycle.
- gnt and add_a/add_b are combinational from req, op_a, op_b, en, state and pointer.
- All other outputs are registered.

## Configuration
- ADDER_ARB_RR_EN defined: round-robin arbitration with a rotating pointer, as above.
- ADDER_ARB_RR_EN undefined: fixed priority, where the lowest index wins. The pointer register is not built.
- Every other behaviour is identical in both builds.

## Test plan
- Reset sequence: reset low 2 cycles, then high → add_rst=1 for 2 edges then 0; gnt=0 throughout HOLD; all outputs at reset values.
- Single request: req=0001, a0=1, b0=1, LAT=1 → gnt=0001 in cycle N; rsp_vld=1, rsp_id=0, rsp_s=2 in cycle N+2; busy high from N+1 to N+2.
- Contention (RR build): req=1111 held 8 cycles with a_i=i, b_i=3 → grants 0,1,2,3,0,1,2,3; responses with s=3,4,5,6 repeated, in order, one per cycle.
- Fixed-priority build: req=0110 held → gnt=0010 every cycle; requester 2 never granted while req[1] stays high.
- en gating: two ops issued, then en=0 with req≠0 → gnt=0; both responses still return; busy falls after the 2nd rsp_vld.
- Reset mid-flight: issue a=2, b=3 and assert reset the next cycle → no rsp_vld ever appears for that op; count=0; add_rst=1.

Source files
------------

// File: rtl/adder_arbiter.sv
// Shares one external registered adder among NREQ requesters, tags results with the requester ID
// and sequences the adder reset. Define ADDER_ARB_RR_EN for round-robin, otherwise fixed priority.
module adder_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 2,
  parameter int LAT  = 1,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] op_a,
  input  logic [NREQ*W-1:0] op_b,
  output logic [NREQ-1:0]   gnt,
  output logic [W-1:0]      add_a,
  output logic [W-1:0]      add_b,
  output logic              add_rst,
  input  logic [W:0]        add_s,
  output logic              rsp_vld,
  output logic [IDW-1:0]    rsp_id,
  output logic [W:0]        rsp_s,
  output logic              busy
);

  localparam int CW = $clog2(LAT + 2);

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             add_rst_q, add_rst_d;
  logic             arb_en_s, found_s, hit_s, issue_s;
  logic [IDW-1:0]   gidx_s, cand_s;
  logic [NREQ-1:0]  gnt_s;
  logic [LAT-1:0]   vld_q, vld_d;
  logic [IDW-1:0]   id_q [LAT];
  logic [IDW-1:0]   id_d [LAT];
  logic             rsp_vld_q, rsp_vld_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [W:0]       rsp_s_q, rsp_s_d;
  logic [CW-1:0]    count_q, count_d;
  logic             busy_q, busy_d;

`ifdef ADDER_ARB_RR_EN
  logic [IDW-1:0]   ptr_q, ptr_d;
`endif

  // Grant search: first pending request from the pointer (RR) or from index 0 (fixed)
  always_comb begin
    arb_en_s = (state_q == ST_RUN) && en;
    found_s  = 1'b0;
    hit_s    = 1'b0;
    gidx_s   = {IDW{1'b0}};
    cand_s   = {IDW{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
`ifdef ADDER_ARB_RR_EN
      cand_s = IDW'((int'(ptr_q) + k) % NREQ);
`else
      cand_s = IDW'(k);
`endif
      hit_s   = arb_en_s && !found_s && req[cand_s];
      gidx_s  = hit_s ? cand_s : gidx_s;
      found_s = found_s | hit_s;
    end
    issue_s = found_s;
    gnt_s   = found_s ? (NREQ'(1) << gidx_s) : {NREQ{1'b0}};
  end

  assign gnt   = gnt_s;
  assign add_a = issue_s ? op_a[int'(gidx_s)*W +: W] : {W{1'b0}};
  assign add_b = issue_s ? op_b[int'(gidx_s)*W +: W] : {W{1'b0}};

`ifdef ADDER_ARB_RR_EN
  // Pointer moves one past the granted index
  always_comb begin
    ptr_d = ptr_q;
    if (issue_s) begin
      ptr_d = (gidx_s == IDW'(NREQ - 1)) ? {IDW{1'b0}} : gidx_s + IDW'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= {IDW{1'b0}};
    else        ptr_q <= ptr_d;
  end
`endif

  // Sequencer: adder reset held through two edges after release
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST:  state_d = ST_HOLD;
      ST_HOLD: state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_RST;
    endcase
    add_rst_d = (state_d != ST_RUN);
  end

  // Tag pipeline, response capture and outstanding count
  always_comb begin
    vld_d = vld_q;
    id_d  = id_q;
    for (int i = LAT - 1; i > 0; i--) begin
      vld_d[i] = vld_q[i-1];
      id_d[i]  = id_q[i-1];
    end
    vld_d[0]  = issue_s;
    id_d[0]   = gidx_s;
    rsp_vld_d = vld_q[LAT-1];
    rsp_id_d  = vld_q[LAT-1] ? id_q[LAT-1] : rsp_id_q;
    rsp_s_d   = vld_q[LAT-1] ? add_s : rsp_s_q;
    case ({issue_s, rsp_vld_q})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    busy_d = (count_d != {CW{1'b0}});
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RST;
      add_rst_q <= 1'b1;
      vld_q     <= {LAT{1'b0}};
      for (int i = 0; i < LAT; i++) id_q[i] <= {IDW{1'b0}};
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= {IDW{1'b0}};
      rsp_s_q   <= {(W+1){1'b0}};
      count_q   <= {CW{1'b0}};
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      add_rst_q <= add_rst_d;
      vld_q     <= vld_d;
      id_q      <= id_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_id_q  <= rsp_id_d;
      rsp_s_q   <= rsp_s_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
    end
  end

  assign add_rst = add_rst_q;
  assign rsp_vld = rsp_vld_q;
  assign rsp_id  = rsp_id_q;
  assign rsp_s   = rsp_s_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: vector table plus reset sequences, with a response scoreboard.
module tb_adder_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] req;
  logic [7:0] op_a, op_b;
  logic [3:0] gnt;
  logic [1:0] add_a, add_b;
  logic       add_rst;
  logic [2:0] add_s = 3'd0;
  logic       rsp_vld;
  logic [1:0] rsp_id;
  logic [2:0] rsp_s;
  logic       busy;

  adder_arbiter dut (
    .clk(clk), .reset(reset), .en(en), .req(req), .op_a(op_a), .op_b(op_b),
    .gnt(gnt), .add_a(add_a), .add_b(add_b), .add_rst(add_rst), .add_s(add_s),
    .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_s(rsp_s), .busy(busy)
  );

  always #5 clk = ~clk;

  // Environment adder: one-cycle registered, active-high reset
  always @(posedge clk) add_s <= add_rst ? 3'd0 : ({1'b0, add_a} + {1'b0, add_b});

  typedef struct { logic [1:0] id; logic [2:0] s; int due; } exp_t;
  typedef struct { logic en; logic [3:0] req; logic [7:0] a; logic [7:0] b; logic [3:0] g_fp; logic [3:0] g_rr; } vec_t;

  exp_t sbq[$];
  vec_t vt[26];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   edges  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] oh2i(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  // One cycle: check combinational outputs and scoreboard at negedge, then advance
  task automatic tick(input logic [3:0] exp_g);
    exp_t       e;
    logic [1:0] gi;
    @(negedge clk);
    chk("gnt", int'(gnt), int'(exp_g));
    chk("add_rst", int'(add_rst), (edges < 2) ? 1 : 0);
    chk("busy", int'(busy), (sbq.size() != 0) ? 1 : 0);
    if (rsp_vld) begin
      if (sbq.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("rsp_due_cycle", cyc, e.due);
        chk("rsp_id", int'(rsp_id), int'(e.id));
        chk("rsp_s", int'(rsp_s), int'(e.s));
      end
    end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      chk("rsp_missing", 0, 1);
    end
    if (exp_g != 4'd0) begin
      gi = oh2i(exp_g);
      chk("add_a", int'(add_a), int'(op_a[int'(gi)*2 +: 2]));
      chk("add_b", int'(add_b), int'(op_b[int'(gi)*2 +: 2]));
      e.id  = gi;
      e.s   = {1'b0, op_a[int'(gi)*2 +: 2]} + {1'b0, op_b[int'(gi)*2 +: 2]};
      e.due = cyc + 2;
      sbq.push_back(e);
    end else begin
      chk("add_a_idle", int'(add_a), 0);
      chk("add_b_idle", int'(add_b), 0);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (reset) edges++;
  endtask

  initial begin
    vt[0]  = '{1'b1, 4'b1111, 8'he4, 8'hff, 4'b0001, 4'b0001};
    vt[1]  = '{1'b1, 4'b1111, 8'he4, 8'hff, 4'b0001, 4'b0010};
    vt[2]  = '{1'b1, 4'b1111, 8'he4, 8'hff, 4'b0001, 4'b0100};
    vt[3]  = '{1'b1, 4'b1111, 8'he4, 8'hff, 4'b0001, 4'b1000};
    vt[4]  = '{1'b1, 4'b1111, 8'he4, 8'hff, 4'b0001, 4'b0001};
    vt[5]  = '{1'b1, 4'b1111, 8'he4, 8'hff, 4'b0001, 4'b0010};
    vt[6]  = '{1'b1, 4'b1111, 8'he4, 8'hff, 4'b0001, 4'b0100};
    vt[7]  = '{1'b1, 4'b1111, 8'he4, 8'hff, 4'b0001, 4'b1000};
    vt[8]  = '{1'b1, 4'b0001, 8'h01, 8'h01, 4'b0001, 4'b0001};
    vt[9]  = '{1'b1, 4'b0000, 8'h00, 8'h00, 4'b0000, 4'b0000};
    vt[10] = '{1'b1, 4'b0000, 8'h00, 8'h00, 4'b0000, 4'b0000};
    vt[11] = '{1'b1, 4'b0110, 8'h24, 8'h18, 4'b0010, 4'b0010};
    vt[12] = '{1'b1, 4'b0110, 8'h24, 8'h18, 4'b0010, 4'b0100};
    vt[13] = '{1'b1, 4'b0110, 8'h24, 8'h18, 4'b0010, 4'b0010};
    vt[14] = '{1'b1, 4'b0110, 8'h24, 8'h18, 4'b0010, 4'b0100};
    vt[15] = '{1'b1, 4'b1010, 8'hc8, 8'hcc, 4'b0010, 4'b1000};
    vt[16] = '{1'b1, 4'b0100, 8'h10, 8'h20, 4'b0100, 4'b0100};
    vt[17] = '{1'b1, 4'b1000, 8'h80, 8'h80, 4'b1000, 4'b1000};
    vt[18] = '{1'b0, 4'b1111, 8'he4, 8'hff, 4'b0000, 4'b0000};
    vt[19] = '{1'b0, 4'b1111, 8'he4, 8'hff, 4'b0000, 4'b0000};
    vt[20] = '{1'b0, 4'b1111, 8'he4, 8'hff, 4'b0000, 4'b0000};
    vt[21] = '{1'b0, 4'b0000, 8'h00, 8'h00, 4'b0000, 4'b0000};
    vt[22] = '{1'b1, 4'b1000, 8'hc0, 8'hc0, 4'b1000, 4'b1000};
    vt[23] = '{1'b1, 4'b0000, 8'h00, 8'h00, 4'b0000, 4'b0000};
    vt[24] = '{1'b1, 4'b0000, 8'h00, 8'h00, 4'b0000, 4'b0000};
    vt[25] = '{1'b1, 4'b0000, 8'h00, 8'h00, 4'b0000, 4'b0000};

    // Power-on reset, then HOLD with requests pending
    reset = 1'b0; en = 1'b0; req = 4'b0000; op_a = 8'h00; op_b = 8'h00;
    tick(4'b0000);
    chk("rst_rsp_vld", int'(rsp_vld), 0);
    chk("rst_rsp_id", int'(rsp_id), 0);
    chk("rst_rsp_s", int'(rsp_s), 0);
    tick(4'b0000);
    reset = 1'b1;
    en = 1'b1; req = 4'b1111; op_a = 8'he4; op_b = 8'hff;
    tick(4'b0000);
    tick(4'b0000);

    foreach (vt[i]) begin
      en = vt[i].en; req = vt[i].req; op_a = vt[i].a; op_b = vt[i].b;
`ifdef ADDER_ARB_RR_EN
      tick(vt[i].g_rr);
`else
      tick(vt[i].g_fp);
`endif
    end

    // Reset asserted the cycle after an issue: the op must never return
    en = 1'b1; req = 4'b0001; op_a = 8'h02; op_b = 8'h03;
    tick(4'b0001);
    reset = 1'b0; req = 4'b0000; op_a = 8'h00; op_b = 8'h00;
    sbq.delete();
    edges = 0;
    tick(4'b0000);
    chk("mid_rsp_id", int'(rsp_id), 0);
    chk("mid_rsp_s", int'(rsp_s), 0);
    tick(4'b0000);
    tick(4'b0000);
    reset = 1'b1;
    tick(4'b0000);
    tick(4'b0000);
    tick(4'b0000);

    // Recovery after reset
    req = 4'b0010; op_a = 8'h0c; op_b = 8'h08;
    tick(4'b0010);
    req = 4'b0000; op_a = 8'h00; op_b = 8'h00;
    tick(4'b0000);
    tick(4'b0000);
    tick(4'b0000);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
